// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial frame receiver.
// Holds the two-bit state encoding of the receive FSM and the default sync
// word settings used by serial_frame_rx and sync_detector.
package serial_rx_pkg;

  typedef logic [1:0] state_t;

  localparam state_t HUNT   = 2'd0;
  localparam state_t DATA   = 2'd1;
  localparam state_t PARITY = 2'd2;
  localparam state_t STOP   = 2'd3;

  localparam int              SYNC_W_DEF       = 4;
  localparam logic [3:0]      SYNC_PATTERN_DEF = 4'b1011;

endpackage

// File: rtl/serial_frame_rx_sync_detector.sv
// Sync word hunter: a SYNC_W-bit history shift register plus a comparator.
// Ports:
//   Clk    clock, rising edge
//   Rst    synchronous active-high reset
//   En     shift strobe; Di enters the history only when En=1
//   clr    synchronous clear of history and match (wins over En)
//   Di     serial bit
//   match  registered: the last shifted-in bit completed SYNC_PATTERN
module sync_detector
  import serial_rx_pkg::*;
#(
  parameter int                SYNC_W       = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic En,
  input  logic clr,
  input  logic Di,
  output logic match
);

  logic [SYNC_W-1:0] history;
  logic [SYNC_W-1:0] shifted;

  // Newest bit lands at the LSB; comparing the post-shift value lets
  // overlapping patterns match as soon as their last bit arrives.
  assign shifted = {history[SYNC_W-2:0], Di};

  // match holds while En is low so the FSM can pick it up on the next
  // strobe; clr is used once the frame has claimed the match.
  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      history <= '0;
      match   <= 1'b0;
    end else if (En) begin
      history <= shifted;
      match   <= (shifted == SYNC_PATTERN);
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync word, deserialises a DATA_W-bit
// payload (MSB first), then checks an even-parity bit and a stop bit.
// Ports:
//   Clk       clock, rising edge
//   Rst       synchronous active-high reset
//   Di        serial data bit
//   En        bit strobe; Di is consumed only when En=1
//   Dout      last good payload, held until the next good frame
//   Valid     1-cycle pulse: good frame on Dout
//   ParErr    1-cycle pulse: parity mismatch
//   FrmErr    1-cycle pulse: stop bit was 0
//   Busy      1 while a frame is being received
//   FrameCnt  count of good frames, wraps 255->0
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Di,
  input  logic              En,
  output logic [DATA_W-1:0] Dout,
  output logic              Valid,
  output logic              ParErr,
  output logic              FrmErr,
  output logic              Busy,
  output logic [7:0]        FrameCnt
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              perr_q;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
  logic              par_err_q;
  logic              frm_err_q;
  logic [7:0]        frame_cnt_q;
  logic              match;

  logic data_take;
  logic par_take;
  logic stop_take;
  logic last_bit;
  logic det_en;
  logic det_clr;

  sync_detector #(
    .SYNC_W       (SYNC_W),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_sync (
    .Clk   (Clk),
    .Rst   (Rst),
    .En    (det_en),
    .clr   (det_clr),
    .Di    (Di),
    .match (match)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (data_take)             state_d = DATA;
      DATA:    if (data_take && last_bit) state_d = PARITY;
      PARITY:  if (par_take)              state_d = STOP;
      STOP:    if (stop_take)             state_d = HUNT;
      default:                            state_d = HUNT;
    endcase
  end

  // Per-cycle control decode. The detector's match is registered, so the
  // HUNT cycle in which match is already set is the first payload cycle:
  // that strobe is taken as payload bit 1 rather than lost.
  always_comb begin
    data_take = En && ((state_q == DATA) || ((state_q == HUNT) && match));
    par_take  = En && (state_q == PARITY);
    stop_take = En && (state_q == STOP);
    last_bit  = (cnt_q == CNT_LAST);
    det_en    = En && (state_q == HUNT) && !match;
    det_clr   = (data_take && (state_q == HUNT)) || stop_take;
  end

  // Payload shifter, bit counter, parity, result pulses and frame counter.
  // Pulses default low every cycle so they last exactly one clock.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      if (data_take) begin
        shift_q <= {shift_q[DATA_W-2:0], Di};
        cnt_q   <= last_bit ? '0 : cnt_q + 1'b1;
      end
      if (par_take) begin
        perr_q <= ^{shift_q, Di};
      end
      if (stop_take) begin
        valid_q   <= Di && !perr_q;
        par_err_q <= perr_q;
        frm_err_q <= !Di;
        if (Di && !perr_q) begin
          dout_q      <= shift_q;
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

  // Busy covers the matched-HUNT cycle too, so it rises right after the
  // last sync bit; both terms are flop outputs.
  assign Busy     = (state_q != HUNT) || match;
  assign Dout     = dout_q;
  assign Valid    = valid_q;
  assign ParErr   = par_err_q;
  assign FrmErr   = frm_err_q;
  assign FrameCnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed testbench for serial_frame_rx: good frames, parity and framing
// errors, overlapping sync, false sync inside payload, En gating, reset
// mid-frame and FrameCnt wrap.
module tb_serial_frame_rx;

  logic       Clk;
  logic       Rst;
  logic       Di;
  logic       En;
  logic [7:0] Dout;
  logic       Valid;
  logic       ParErr;
  logic       FrmErr;
  logic       Busy;
  logic [7:0] FrameCnt;

  int errors;
  int checks;
  int valid_seen;
  int pulse_seen;

  serial_frame_rx dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Di       (Di),
    .En       (En),
    .Dout     (Dout),
    .Valid    (Valid),
    .ParErr   (ParErr),
    .FrmErr   (FrmErr),
    .Busy     (Busy),
    .FrameCnt (FrameCnt)
  );

  // 40-unit clock period
  initial begin
    Clk = 1'b0;
    forever #20 Clk = ~Clk;
  end

  // Drive one bit on the falling edge, then sample #1 after the rising edge.
  task automatic apply_bit(input logic b, input logic en);
    @(negedge Clk);
    Di = b;
    En = en;
    @(posedge Clk);
    #1;
    if (Valid) valid_seen++;
    if (Valid || ParErr || FrmErr) pulse_seen++;
  endtask

  task automatic send_sync();
    logic [3:0] sync;
    sync = 4'b1011;
    for (int i = 3; i >= 0; i--) apply_bit(sync[i], 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic p, input logic s);
    send_sync();
    for (int i = 7; i >= 0; i--) apply_bit(data[i], 1'b1);
    apply_bit(p, 1'b1);
    apply_bit(s, 1'b1);
  endtask

  // Same frame, but every strobe is followed by an En=0 cycle carrying the
  // inverted bit, which must be ignored.
  task automatic send_frame_gapped(input logic [7:0] data, input logic p, input logic s);
    logic [3:0] sync;
    sync = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      apply_bit(sync[i], 1'b1);
      apply_bit(!sync[i], 1'b0);
    end
    for (int i = 7; i >= 0; i--) begin
      apply_bit(data[i], 1'b1);
      apply_bit(!data[i], 1'b0);
    end
    apply_bit(p, 1'b1);
    apply_bit(!p, 1'b0);
    apply_bit(s, 1'b1);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] d;
    errors     = 0;
    checks     = 0;
    valid_seen = 0;
    pulse_seen = 0;
    Rst = 1'b1;
    En  = 1'b0;
    Di  = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    apply_bit(1'b0, 1'b0);

    // Reset state
    check_output("reset_valid",  32'(Valid),    32'd0);
    check_output("reset_parerr", 32'(ParErr),   32'd0);
    check_output("reset_frmerr", 32'(FrmErr),   32'd0);
    check_output("reset_busy",   32'(Busy),     32'd0);
    check_output("reset_cnt",    32'(FrameCnt), 32'd0);
    check_output("reset_dout",   32'(Dout),     32'd0);
    apply_bit(1'b0, 1'b1);
    apply_bit(1'b0, 1'b1);

    // Good frame A5
    send_frame(8'hA5, 1'b0, 1'b1);
    check_output("good_valid",  32'(Valid),    32'd1);
    check_output("good_dout",   32'(Dout),     32'hA5);
    check_output("good_cnt",    32'(FrameCnt), 32'd1);
    check_output("good_parerr", 32'(ParErr),   32'd0);
    check_output("good_frmerr", 32'(FrmErr),   32'd0);
    check_output("good_busy",   32'(Busy),     32'd0);
    apply_bit(1'b0, 1'b1);
    check_output("good_valid_1cyc", 32'(Valid), 32'd0);

    // Parity error: 66 has four ones, p=1 makes it odd
    send_frame(8'h66, 1'b1, 1'b1);
    check_output("perr_parerr", 32'(ParErr),   32'd1);
    check_output("perr_valid",  32'(Valid),    32'd0);
    check_output("perr_frmerr", 32'(FrmErr),   32'd0);
    check_output("perr_dout",   32'(Dout),     32'hA5);
    check_output("perr_cnt",    32'(FrameCnt), 32'd1);
    apply_bit(1'b0, 1'b1);
    check_output("perr_1cyc",   32'(ParErr),   32'd0);

    // Framing error then a good frame
    send_frame(8'h3C, 1'b0, 1'b0);
    check_output("ferr_frmerr", 32'(FrmErr),   32'd1);
    check_output("ferr_parerr", 32'(ParErr),   32'd0);
    check_output("ferr_valid",  32'(Valid),    32'd0);
    check_output("ferr_dout",   32'(Dout),     32'hA5);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_output("after_ferr_valid", 32'(Valid),    32'd1);
    check_output("after_ferr_dout",  32'(Dout),     32'h5A);
    check_output("after_ferr_cnt",   32'(FrameCnt), 32'd2);

    // Parity and framing error together
    send_frame(8'h01, 1'b0, 1'b0);
    check_output("both_parerr", 32'(ParErr), 32'd1);
    check_output("both_frmerr", 32'(FrmErr), 32'd1);
    check_output("both_valid",  32'(Valid),  32'd0);

    // Overlapping sync 101011 after idle zeros
    repeat (3) apply_bit(1'b0, 1'b1);
    apply_bit(1'b1, 1'b1);
    apply_bit(1'b0, 1'b1);
    apply_bit(1'b1, 1'b1);
    apply_bit(1'b0, 1'b1);
    apply_bit(1'b1, 1'b1);
    check_output("ovl_busy_bit5", 32'(Busy), 32'd0);
    apply_bit(1'b1, 1'b1);
    check_output("ovl_busy_bit6", 32'(Busy), 32'd1);
    d = 8'hC3;
    for (int i = 7; i >= 0; i--) apply_bit(d[i], 1'b1);
    check_output("ovl_busy_payload", 32'(Busy), 32'd1);
    apply_bit(1'b0, 1'b1);
    apply_bit(1'b1, 1'b1);
    check_output("ovl_valid", 32'(Valid), 32'd1);
    check_output("ovl_dout",  32'(Dout),  32'hC3);

    // Payload containing 1011 must not restart the frame
    send_frame(8'hB0, 1'b1, 1'b1);
    check_output("fsync_valid", 32'(Valid),    32'd1);
    check_output("fsync_dout",  32'(Dout),     32'hB0);
    check_output("fsync_cnt",   32'(FrameCnt), 32'd4);

    // En gating with Di toggling in the gaps
    send_frame_gapped(8'hA5, 1'b0, 1'b1);
    check_output("gap_valid", 32'(Valid),    32'd1);
    check_output("gap_dout",  32'(Dout),     32'hA5);
    check_output("gap_cnt",   32'(FrameCnt), 32'd5);
    apply_bit(1'b1, 1'b0);
    check_output("gap_valid_en0", 32'(Valid), 32'd0);

    // Reset after four payload bits
    send_sync();
    apply_bit(1'b1, 1'b1);
    apply_bit(1'b0, 1'b1);
    apply_bit(1'b1, 1'b1);
    apply_bit(1'b0, 1'b1);
    check_output("rst_busy_before", 32'(Busy), 32'd1);
    @(negedge Clk);
    Rst = 1'b1;
    En  = 1'b1;
    Di  = 1'b1;
    @(posedge Clk);
    #1;
    check_output("rst_busy",  32'(Busy),     32'd0);
    check_output("rst_cnt",   32'(FrameCnt), 32'd0);
    check_output("rst_dout",  32'(Dout),     32'd0);
    check_output("rst_valid", 32'(Valid),    32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    pulse_seen = 0;
    apply_bit(1'b0, 1'b1);
    apply_bit(1'b1, 1'b1);
    apply_bit(1'b0, 1'b1);
    apply_bit(1'b1, 1'b1);
    apply_bit(1'b0, 1'b1);
    apply_bit(1'b1, 1'b1);
    check_output("rst_no_pulses", 32'(pulse_seen), 32'd0);
    check_output("rst_busy_after", 32'(Busy), 32'd0);

    // 256 back-to-back good frames wrap FrameCnt
    repeat (4) apply_bit(1'b0, 1'b1);
    valid_seen = 0;
    for (int i = 0; i < 256; i++) begin
      d = 8'(i);
      send_frame(d, ^d, 1'b1);
      if (i == 254) check_output("wrap_cnt_255", 32'(FrameCnt), 32'd255);
    end
    check_output("wrap_cnt_0",   32'(FrameCnt),   32'd0);
    check_output("wrap_valids",  32'(valid_seen), 32'd256);
    check_output("wrap_dout",    32'(Dout),       32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
